// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned CONST_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Largest value representable in 'digits' decimal digits; callers cast to their register width.
    function automatic logic [CONST_W-1:0] pow10_minus1(input int unsigned digits);
        logic [CONST_W-1:0] p;
        p = CONST_W'(1);
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * CONST_W'(10);
        end
        return p - CONST_W'(1);
    endfunction

    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_blank_mask.sv
// Leading-zero blanking mask for a packed BCD value; the units digit is never blanked.
module bcd_blank_mask #(
    parameter int unsigned DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]   blank_c
);

    logic [DIGITS-1:0] zero_from;

    // zero_from[i] is set when digit i and every digit above it are zero.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        zero_from = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero     = all_zero & (bcd[4*i +: 4] == 4'd0);
            zero_from[i] = all_zero;
        end
    end

    assign blank_c = zero_from & ~DIGITS'(1);

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter with valid/ready handshakes,
// overflow flag and leading-zero blanking mask.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned WR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [WR_W-1:0]   MAX_VAL   = WR_W'(pow10_minus1(DIGITS));
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_W - 1);

    state_e              state_q, state_d;
    logic [WR_W-1:0]     work_q, work_d;
    logic [WR_W-1:0]     corr_c, work_step_c;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d, blank_c;
    logic                ovf_q, ovf_d;
    logic                ovf_r_q, ovf_r_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                last_shift_c;

    assign last_shift_c = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // One double-dabble step: correct every BCD field, then shift; the top bit falls off.
    always_comb begin
        corr_c = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            corr_c[BIN_W + 4*i +: 4] = add3_digit(work_q[BIN_W + 4*i +: 4]);
        end
        work_step_c = corr_c << 1;
    end

    bcd_blank_mask #(.DIGITS(DIGITS)) u_blank (
        .bcd     (work_step_c[WR_W-1:BIN_W]),
        .blank_c (blank_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)     state_d = SHIFT;
            SHIFT:   if (last_shift_c) state_d = DONE;
            DONE:    if (out_ready)    state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        work_d      = work_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        ovf_d       = ovf_q;
        ovf_r_d     = ovf_r_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = WR_W'(bin_in);
                    cnt_d   = '0;
                    ovf_r_d = (WR_W'(bin_in) > MAX_VAL);
                end
            end
            SHIFT: begin
                work_d = work_step_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_shift_c) begin
                    bcd_d   = work_step_c[WR_W-1:BIN_W];
                    blank_d = blank_c;
                    ovf_d   = ovf_r_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q      <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= BLANK_RST;
            ovf_q       <= 1'b0;
            ovf_r_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            ovf_q       <= ovf_d;
            ovf_r_q     <= ovf_r_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign blank     = blank_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases on 9b/3-digit and 9b/2-digit
// instances plus a randomised handshake sweep on a 16b/5-digit instance.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance a: BIN_W=9, DIGITS=3
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [8:0]  a_bin;
    logic [11:0] a_bcd;
    logic [2:0]  a_blank;
    // Instance b: BIN_W=9, DIGITS=2
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
    logic [8:0]  b_bin;
    logic [7:0]  b_bcd;
    logic [1:0]  b_blank;
    // Instance c: BIN_W=16, DIGITS=5
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
    logic [15:0] c_bin;
    logic [19:0] c_bcd;
    logic [4:0]  c_blank;

    bin2bcd_seq #(.BIN_W(9), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .bin_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd(a_bcd), .blank(a_blank), .ovf(a_ovf));

    bin2bcd_seq #(.BIN_W(9), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .bin_in(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bcd(b_bcd), .blank(b_blank), .ovf(b_ovf));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .bin_in(c_bin), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .bcd(c_bcd), .blank(c_blank), .ovf(c_ovf));

    // Reference model: plain decimal arithmetic.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] ref_bcd(input longint unsigned v, input int d);
        logic [31:0] r = '0;
        longint unsigned x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_blank(input longint unsigned v, input int d);
        logic [7:0] r = '0;
        longint unsigned m = v % pow10(d);
        for (int i = 1; i < d; i++) r[i] = ((m / pow10(i)) == 0);
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int d);
        return v > (pow10(d) - 1);
    endfunction

    // Handshake drivers (no checking): present v, count edges until out_valid.
    task automatic run_a(input logic [8:0] v, output int lat, output bit tout);
        a_bin = v; a_in_valid = 1'b1; lat = 0; tout = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        while (a_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) tout = 1'b1;
    endtask

    task automatic release_a();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic run_b(input logic [8:0] v, output int lat, output bit tout);
        b_bin = v; b_in_valid = 1'b1; lat = 0; tout = 1'b0;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        while (b_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) tout = 1'b1;
        b_out_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
        n_cmp++; if (a_bcd !== 12'h000) begin n_err++; $display("FAIL rst_bcd: got %h want 000", a_bcd); end
        n_cmp++; if (a_blank !== 3'b110) begin n_err++; $display("FAIL rst_blank: got %b want 110", a_blank); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", a_ovf); end
        n_cmp++; if (c_blank !== 5'b11110) begin n_err++; $display("FAIL rst_blank_c: got %b want 11110", c_blank); end
    endtask

    task automatic test_zero();
        int lat; bit tout;
        run_a(9'd0, lat, tout);
        n_cmp++; if (tout || lat != 9) begin n_err++; $display("FAIL zero_latency: got %0d edges want 9", lat); end
        n_cmp++; if (a_bcd !== 12'h000) begin n_err++; $display("FAIL zero_bcd: got %h want 000", a_bcd); end
        n_cmp++; if (a_blank !== 3'b110) begin n_err++; $display("FAIL zero_blank: got %b want 110", a_blank); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL zero_ovf: got %b want 0", a_ovf); end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL zero_in_ready_done: got %b want 0", a_in_ready); end
        release_a();
        n_cmp++; if ({a_in_ready, a_out_valid} !== 2'b10) begin n_err++; $display("FAIL zero_release: got rdy/vld %b want 10", {a_in_ready, a_out_valid}); end
    endtask

    task automatic test_values();
        logic [8:0]  vals [4];
        logic [11:0] eb   [4];
        logic [2:0]  ebl  [4];
        logic [8:0]  v;
        int lat; bit tout;
        vals = '{9'd255, 9'd511, 9'd5, 9'd47};
        eb   = '{12'h255, 12'h511, 12'h005, 12'h047};
        ebl  = '{3'b000, 3'b000, 3'b110, 3'b100};
        for (int i = 0; i < 4; i++) begin
            run_a(vals[i], lat, tout);
            n_cmp++; if (tout || a_bcd !== eb[i]) begin n_err++; $display("FAIL val_bcd[%0d]: got %h want %h", vals[i], a_bcd, eb[i]); end
            n_cmp++; if (a_blank !== ebl[i]) begin n_err++; $display("FAIL val_blank[%0d]: got %b want %b", vals[i], a_blank, ebl[i]); end
            release_a();
        end
        for (int i = 0; i < 6; i++) begin
            v = 9'($urandom);
            run_a(v, lat, tout);
            n_cmp++; if (tout || a_bcd !== 12'(ref_bcd(64'(v), 3))) begin n_err++; $display("FAIL rnd_bcd[%0d]: got %h want %h", v, a_bcd, 12'(ref_bcd(64'(v), 3))); end
            n_cmp++; if (a_blank !== 3'(ref_blank(64'(v), 3))) begin n_err++; $display("FAIL rnd_blank[%0d]: got %b want %b", v, a_blank, 3'(ref_blank(64'(v), 3))); end
            release_a();
        end
    endtask

    task automatic test_overflow();
        logic [8:0] vals [3];
        logic [7:0] eb   [3];
        logic [1:0] ebl  [3];
        logic       eo   [3];
        int lat; bit tout;
        vals = '{9'd100, 9'd99, 9'd511};
        eb   = '{8'h00, 8'h99, 8'h11};
        ebl  = '{2'b10, 2'b00, 2'b00};
        eo   = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_b(vals[i], lat, tout);
            n_cmp++; if (tout || b_ovf !== eo[i]) begin n_err++; $display("FAIL ovf_flag[%0d]: got %b want %b", vals[i], b_ovf, eo[i]); end
            n_cmp++; if (b_bcd !== eb[i]) begin n_err++; $display("FAIL ovf_bcd[%0d]: got %h want %h", vals[i], b_bcd, eb[i]); end
            n_cmp++; if (b_blank !== ebl[i]) begin n_err++; $display("FAIL ovf_blank[%0d]: got %b want %b", vals[i], b_blank, ebl[i]); end
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int pulses = 0;
        int w = 0;
        a_bin = 9'd123; a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk); #1;
            if (a_out_valid === 1'b1) begin
                n_cmp++; if (a_bcd !== 12'h123) begin n_err++; $display("FAIL b2b_bcd: got %h want 123", a_bcd); end
                if (last >= 0) begin
                    n_cmp++; if (cyc - last != 11) begin n_err++; $display("FAIL b2b_interval: got %0d want 11", cyc - last); end
                end
                last = cyc;
                pulses++;
            end
        end
        n_cmp++; if (pulses != 4) begin n_err++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
        a_in_valid = 1'b0;
        while (!(a_in_ready === 1'b1 && a_out_valid === 1'b0) && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++; if (w >= 30) begin n_err++; $display("FAIL b2b_drain: got no idle within %0d cycles want idle", w); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat; bit tout;
        run_a(9'd123, lat, tout);
        n_cmp++; if (tout) begin n_err++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin a_bin = 9'd77; a_in_valid = 1'b1; end
            if (i == 17) a_in_valid = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if ({a_out_valid, a_in_ready, a_bcd, a_blank, a_ovf} !== {1'b1, 1'b0, 12'h123, 3'b000, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b bcd=%h blank=%b ovf=%b want 1 0 123 000 0",
                         i, a_out_valid, a_in_ready, a_bcd, a_blank, a_ovf);
            end
        end
        release_a();
        n_cmp++; if ({a_in_ready, a_out_valid, a_bcd} !== {1'b1, 1'b0, 12'h123}) begin n_err++; $display("FAIL bp_release: got rdy=%b vld=%b bcd=%h want 1 0 123", a_in_ready, a_out_valid, a_bcd); end
    endtask

    task automatic test_reset_mid();
        int lat; bit tout;
        a_bin = 9'd300; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({a_out_valid, a_in_ready, a_bcd, a_blank} !== {1'b0, 1'b1, 12'h000, 3'b110}) begin n_err++; $display("FAIL midrst_async: got vld=%b rdy=%b bcd=%h blank=%b want 0 1 000 110", a_out_valid, a_in_ready, a_bcd, a_blank); end
        @(posedge clk); #1;
        n_cmp++; if ({a_out_valid, a_bcd} !== {1'b0, 12'h000}) begin n_err++; $display("FAIL midrst_held: got vld=%b bcd=%h want 0 000", a_out_valid, a_bcd); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_a(9'd300, lat, tout);
        n_cmp++; if (tout || lat != 9) begin n_err++; $display("FAIL midrst_latency: got %0d want 9", lat); end
        n_cmp++; if ({a_bcd, a_blank, a_ovf} !== {12'h300, 3'b000, 1'b0}) begin n_err++; $display("FAIL midrst_result: got bcd=%h blank=%b ovf=%b want 300 000 0", a_bcd, a_blank, a_ovf); end
        release_a();
    endtask

    task automatic test_random();
        localparam int N = 30;
        logic [15:0] q[$];
        logic [15:0] v, e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit pend = 1'b0;
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        while (got < N && cyc < 4000) begin
            if (!pend && sent < N && $urandom_range(0, 9) < 6) begin
                v = (sent == 0) ? 16'd0 : (sent == 1) ? 16'hFFFF : 16'($urandom);
                c_bin = v; c_in_valid = 1'b1; pend = 1'b1;
            end
            c_out_ready = ($urandom_range(0, 1) == 1);
            if (c_out_valid === 1'b1 && c_out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra: got unexpected result %h want none", c_bcd);
                end else begin
                    e = q.pop_front();
                    if ({c_bcd, c_blank, c_ovf} !== {20'(ref_bcd(64'(e), 5)), 5'(ref_blank(64'(e), 5)), ref_ovf(64'(e), 5)}) begin
                        n_err++;
                        $display("FAIL rand_result[%0d]: got bcd=%h blank=%b ovf=%b want bcd=%h blank=%b ovf=%b",
                                 e, c_bcd, c_blank, c_ovf, 20'(ref_bcd(64'(e), 5)), 5'(ref_blank(64'(e), 5)), ref_ovf(64'(e), 5));
                    end
                end
                got++;
            end
            if (c_in_valid && c_in_ready === 1'b1) begin
                q.push_back(c_bin);
                sent++;
                pend = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (!pend) c_in_valid = 1'b0;
        end
        n_cmp++; if (got != N) begin n_err++; $display("FAIL rand_count: got %0d results want %0d", got, N); end
        c_out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_bin = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_bin = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_zero();
        test_values();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using shift-add-3 (double dabble), one shift per clock.
- Replaces the fixed 9-bit single-cycle converter in front of the 7-segment display path.
- Adds a valid/ready handshake, an arbitrary input width, a configurable digit count, an overflow flag and a leading-zero blanking mask.

Parameters:
- BIN_W, 9, binary input width (>=1).
- DIGITS, 3, number of BCD output digits (>=1). Overflow is flagged when the input exceeds 10^DIGITS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  bin_in is valid.
- in_ready  out  1  block can accept a new value.
- bin_in  in  BIN_W  unsigned binary value.
- out_valid  out  1  result registers are valid.
- out_ready  in  1  consumer takes the result.
- bcd  out  4*DIGITS  packed BCD; digit 0 (units) is at [3:0].
- blank  out  DIGITS  bit i=1 when digit i is a leading zero; bit 0 is always 0.
- ovf  out  1  input exceeded 10^DIGITS-1.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All flops are reset by rst_n.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - bcd=0, blank={DIGITS-1{1},0}, ovf=0, counter=0, working register=0.
- Working register: width 4*DIGITS+BIN_W; BCD field in the upper bits, binary in the lower BIN_W bits.
- Counter: width $clog2(BIN_W+1).
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid (handshake edge): load working register = {0, bin_in}, counter=0, ovf_r = (bin_in > 10^DIGITS-1), go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge: for every digit field, if value >4 add 3 (4-bit, no carry out); then shift the whole register left 1; counter++.
  - When the counter reaches BIN_W-1 on that edge (i.e. after BIN_W shifts): capture bcd (upper field after the final shift), compute blank, drive ovf=ovf_r, go to DONE.
- DONE:
  - out_valid=1; bcd, blank and ovf are held stable.
  - On out_ready: out_valid=0, go to IDLE.
  - in_ready=0 in DONE; there is no accept-while-done.
- Latency: out_valid rises BIN_W edges after the accepting edge. Throughput is 1 result per BIN_W+2 cycles with out_ready tied high.
- Blank mask: scan from digit DIGITS-1 down. blank[i]=1 while all digits >=i are zero; units digit never blanked. Input 0 gives blank={1..1,0}.
- Overflow: bcd carries the low DIGITS decimal digits of the true value. Bits shifted out of the top are discarded; the corrections are unaffected because each digit depends only on lower bits.
- Outputs are registered. bcd/blank/ovf only change on the SHIFT->DONE edge or on reset.
- in_valid while not in IDLE is ignored; the source must hold the value.
- out_ready while not in DONE is ignored.
- Reset mid-SHIFT or mid-DONE: immediate return to the reset values; the partial result is discarded.
- BIN_W=1: a single SHIFT cycle.

Decomposition:
- Package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - function pow10_minus1(DIGITS) returning a 4*DIGITS+BIN_W-wide constant;
  - function add3_digit(4-bit) returning the corrected digit.
- One sub-module, bcd_blank_mask: combinational leading-zero mask generator, parametrised by DIGITS, instantiated on the final BCD value before registering.

Test Plan:
- Reset, then bin_in=0, in_valid pulse -> after 9 edges out_valid=1, bcd=12'h000, blank=3'b110, ovf=0.
- bin_in=255 -> bcd=12'h255, blank=3'b000. Then bin_in=511 -> bcd=12'h511.
- bin_in=5 and bin_in=47 -> bcd=12'h005 / blank=3'b110, and bcd=12'h047 / blank=3'b100.
- Instance DIGITS=2, BIN_W=9, bin_in=100 -> ovf=1, bcd=8'h00, blank=2'b10. Then bin_in=99 -> ovf=0, bcd=8'h99.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next edge, in_ready=1.
- Reset asserted on the 4th SHIFT edge with bin_in=300 -> out_valid=0, bcd=0 immediately (asynchronous). After release, a new conversion of 300 -> bcd=12'h300.
- Random sweep of BIN_W=16, DIGITS=5 against a reference model, with randomised in_valid/out_ready gaps.
